instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 33 +++
 rtl/instr_fetch_pc_next.sv | 22 ++
 rtl/instr_fetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: generic word types (common) and
// fetch-pipe payloads, FSM states and the reset PC (pipes).
package common;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;
    typedef u64          word_t;
endpackage

package pipes;
    import common::*;

    localparam u64          PCINIT      = 64'h8000_0000;
    localparam int unsigned INSTR_BYTES = 4;

    // One fetched instruction handed to decode
    typedef struct packed {
        u32 raw_instr;
        u64 pc;
    } fetch_data_t;

    typedef enum logic {
        S_REQ,
        S_HOLD
    } fetch_state_t;

    // Source for the next fetch PC
    typedef enum logic [1:0] {
        PC_KEEP,
        PC_INC,
        PC_REDIR,
        PC_PEND
    } pc_sel_t;
endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC select: hold, sequential +4 (64-bit wrap), redirect target or
// the target parked while a request was still outstanding.
module pc_next (
    input  logic [63:0]   pc,
    input  logic [63:0]   redirect_pc,
    input  logic [63:0]   pend_pc,
    input  pipes::pc_sel_t sel,
    output logic [63:0]   pc_nxt_c
);
    import pipes::*;

    // Pure mux; the adder wraps naturally at 64 bits
    always_comb begin
        pc_nxt_c = pc;
        case (sel)
            PC_INC:   pc_nxt_c = pc + 64'(INSTR_BYTES);
            PC_REDIR: pc_nxt_c = redirect_pc;
            PC_PEND:  pc_nxt_c = pend_pc;
            default:  pc_nxt_c = pc;
        endcase
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding bus request, a one-entry hold
// buffer for decode back-pressure and redirect handling that never cancels
// a request already on the bus.
// Optional performance counters: define FETCH_PERF_CNT_EN.
module instr_fetch #(
    parameter logic [63:0] PCINIT = pipes::PCINIT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ireq_valid,
    output logic [63:0]        ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [31:0]        iresp_data,
    output pipes::fetch_data_t dataF,
    output logic               validF,
    input  logic               ready_d,
`ifdef FETCH_PERF_CNT_EN
    output logic [63:0]        cnt_fetched,
    output logic [63:0]        cnt_stall,
`endif
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc
);
    import common::*;
    import pipes::*;

    fetch_state_t state, state_n;
    pc_sel_t      pc_sel;
    u64           pc, pc_nxt_c;
    u64           pend_pc, pend_pc_n;
    logic         pend_valid, pend_valid_n;
    fetch_data_t  hold, hold_n, data_n;
    logic         valid_n, ireq_valid_n;
    logic         acc, adv;

    // acc: response accepted this cycle; adv: dataF slot free next edge
    assign acc       = ireq_valid && iresp_data_ok;
    assign adv       = !validF || ready_d;
    assign ireq_addr = pc;

    pc_next u_pc_next (
        .pc          (pc),
        .redirect_pc (redirect_pc),
        .pend_pc     (pend_pc),
        .sel         (pc_sel),
        .pc_nxt_c    (pc_nxt_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_n;
        end
    end

    // Next state and datapath controls; redirect outranks everything else
    always_comb begin
        state_n      = state;
        pc_sel       = PC_KEEP;
        valid_n      = validF && !ready_d;
        data_n       = dataF;
        hold_n       = hold;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        ireq_valid_n = 1'b0;

        if (redirect_valid) begin
            valid_n = 1'b0;
            state_n = S_REQ;
            if (ireq_valid && !iresp_data_ok) begin
                // request still in flight: park the target, drop its data later
                pend_valid_n = 1'b1;
                pend_pc_n    = redirect_pc;
            end else begin
                pend_valid_n = 1'b0;
                pc_sel       = PC_REDIR;
            end
        end else if (state == S_HOLD) begin
            if (ready_d) begin
                data_n  = hold;
                valid_n = 1'b1;
                state_n = S_REQ;
            end
        end else if (acc) begin
            if (pend_valid) begin
                pend_valid_n = 1'b0;
                pc_sel       = PC_PEND;
            end else if (adv) begin
                data_n  = '{raw_instr: iresp_data, pc: pc};
                valid_n = 1'b1;
                pc_sel  = PC_INC;
            end else begin
                hold_n  = '{raw_instr: iresp_data, pc: pc};
                pc_sel  = PC_INC;
                state_n = S_HOLD;
            end
        end

        // A new request goes out once the previous one has completed
        ireq_valid_n = (state_n == S_REQ) && !acc;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= PCINIT;
            ireq_valid <= 1'b0;
            validF     <= 1'b0;
            dataF      <= '0;
            hold       <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            pc         <= pc_nxt_c;
            ireq_valid <= ireq_valid_n;
            validF     <= valid_n;
            dataF      <= data_n;
            hold       <= hold_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Handoff and bus-stall event counters, free-running with wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_fetched <= '0;
            cnt_stall   <= '0;
        end else begin
            cnt_fetched <= cnt_fetched + 64'(validF && ready_d);
            cnt_stall   <= cnt_stall + 64'(ireq_valid && !iresp_data_ok);
        end
    end
`endif
endmodule
